// File: rtl/bpio_pwm_bank_if.sv
// Memory-controller bus bundle for the BPIO PWM bank.
// The MCU side is the master; the register bank is the slave.
interface bpio_pwm_bank_if #(
  parameter int MC_ADD_WIDTH  = 6,
  parameter int MC_DATA_WIDTH = 16
);
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_in;
  logic [MC_DATA_WIDTH-1:0] mc_data_out;
  logic                     mc_data_oe;

  modport master (
    output mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    input  mc_data_out, mc_data_oe
  );

  modport slave (
    input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    output mc_data_out, mc_data_oe
  );
endinterface

// File: rtl/bpio_pwm_bank.sv
// Multi-channel PWM bank for the BPIO pins with double-buffered period/duty,
// per-channel polarity and wrap ticks, programmed over the async MCU bus.
module bpio_pwm_bank #(
  parameter int                      CHANNELS      = 5,
  parameter int                      CNT_WIDTH     = 16,
  parameter int                      MC_ADD_WIDTH  = 6,
  parameter int                      MC_DATA_WIDTH = 16,
  parameter logic [MC_ADD_WIDTH-1:0] BASE_ADD      = 6'h08
) (
  input  logic                clock,
  input  logic                reset,
  bpio_pwm_bank_if.slave      bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] period_tick
);
  localparam int NREG = 2 * CHANNELS + 2;
  localparam logic [MC_ADD_WIDTH-1:0] CTRL_OFF = MC_ADD_WIDTH'(2 * CHANNELS);
  localparam logic [MC_ADD_WIDTH-1:0] POL_OFF  = MC_ADD_WIDTH'(2 * CHANNELS + 1);

  logic                    we_s1_q, we_s1_d, we_s2_q, we_s2_d, we_s3_q, we_s3_d;
  logic [1:0]              init_q, init_d;
  logic                    armed_q, armed_d;
  logic [CNT_WIDTH-1:0]    per_pend_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]    per_pend_d  [CHANNELS];
  logic [CNT_WIDTH-1:0]    duty_pend_q [CHANNELS];
  logic [CNT_WIDTH-1:0]    duty_pend_d [CHANNELS];
  logic [CNT_WIDTH-1:0]    per_act_q   [CHANNELS];
  logic [CNT_WIDTH-1:0]    per_act_d   [CHANNELS];
  logic [CNT_WIDTH-1:0]    duty_act_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]    duty_act_d  [CHANNELS];
  logic [CNT_WIDTH-1:0]    cnt_q       [CHANNELS];
  logic [CNT_WIDTH-1:0]    cnt_d       [CHANNELS];
  logic [CHANNELS-1:0]     ctrl_q, ctrl_d;
  logic [CHANNELS-1:0]     pol_q, pol_d;
  logic [CHANNELS-1:0]     pwm_q, pwm_d;
  logic [MC_ADD_WIDTH-1:0] off;
  logic                    in_map;
  logic                    commit;
  logic                    rd_en;
  logic [CNT_WIDTH-1:0]    wdata;

  always_comb begin
    off    = bus.mc_add - BASE_ADD;
    in_map = int'(off) < NREG;
    wdata  = bus.mc_data_in[CNT_WIDTH-1:0];
  end

  // A strobe may only commit once the synchroniser has seen a real idle-high
  // sample after reset, so a write caught by reset is dropped, not replayed.
  always_comb begin
    we_s1_d = bus.mc_we;
    we_s2_d = we_s1_q;
    we_s3_d = we_s2_q;
    init_d  = {init_q[0], 1'b1};
    armed_d = armed_q | (init_q[1] & we_s2_q);
    commit  = armed_q & we_s3_q & ~we_s2_q & ~bus.mc_ce & in_map;
  end

  always_comb begin
    per_pend_d  = per_pend_q;
    duty_pend_d = duty_pend_q;
    ctrl_d      = ctrl_q;
    pol_d       = pol_q;
    if (commit) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (off == MC_ADD_WIDTH'(2 * i))     per_pend_d[i]  = wdata;
        if (off == MC_ADD_WIDTH'(2 * i + 1)) duty_pend_d[i] = wdata;
      end
      if (off == CTRL_OFF) ctrl_d = bus.mc_data_in[CHANNELS-1:0];
      if (off == POL_OFF)  pol_d  = bus.mc_data_in[CHANNELS-1:0];
    end
  end

  // Shadow registers reload only at a wrap (or continuously while disabled),
  // which is what keeps period/duty updates free of runt pulses.
  always_comb begin
    per_act_d   = per_act_q;
    duty_act_d  = duty_act_q;
    cnt_d       = cnt_q;
    pwm_d       = pol_q;
    period_tick = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      period_tick[i] = ctrl_q[i] && (cnt_q[i] == per_act_q[i]);
      cnt_d[i]       = (ctrl_q[i] && !period_tick[i]) ? cnt_q[i] + CNT_WIDTH'(1) : '0;
      if (!ctrl_q[i] || period_tick[i]) begin
        per_act_d[i]  = per_pend_q[i];
        duty_act_d[i] = duty_pend_q[i];
      end
      if (ctrl_q[i]) pwm_d[i] = (cnt_q[i] < duty_act_q[i]) ^ pol_q[i];
    end
    pwm_out = pwm_q;
  end

  always_comb begin
    rd_en           = reset & ~bus.mc_ce & ~bus.mc_oe & in_map;
    bus.mc_data_oe  = rd_en;
    bus.mc_data_out = '0;
    if (rd_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (off == MC_ADD_WIDTH'(2 * i))     bus.mc_data_out = MC_DATA_WIDTH'(per_pend_q[i]);
        if (off == MC_ADD_WIDTH'(2 * i + 1)) bus.mc_data_out = MC_DATA_WIDTH'(duty_pend_q[i]);
      end
      if (off == CTRL_OFF) bus.mc_data_out = MC_DATA_WIDTH'(ctrl_q);
      if (off == POL_OFF)  bus.mc_data_out = MC_DATA_WIDTH'(pol_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      we_s1_q <= 1'b1;
      we_s2_q <= 1'b1;
      we_s3_q <= 1'b1;
      init_q  <= '0;
      armed_q <= 1'b0;
      ctrl_q  <= '0;
      pol_q   <= '0;
      pwm_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        per_pend_q[i]  <= '0;
        duty_pend_q[i] <= '0;
        per_act_q[i]   <= '0;
        duty_act_q[i]  <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      we_s1_q     <= we_s1_d;
      we_s2_q     <= we_s2_d;
      we_s3_q     <= we_s3_d;
      init_q      <= init_d;
      armed_q     <= armed_d;
      ctrl_q      <= ctrl_d;
      pol_q       <= pol_d;
      pwm_q       <= pwm_d;
      per_pend_q  <= per_pend_d;
      duty_pend_q <= duty_pend_d;
      per_act_q   <= per_act_d;
      duty_act_q  <= duty_act_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: tb/tb_bpio_pwm_bank.sv
// Randomised bench for bpio_pwm_bank: register map, reset behaviour and PWM
// waveforms predicted from period/duty arithmetic rather than a counter copy.
module tb_bpio_pwm_bank;
  localparam int CH    = 5;
  localparam int BASE  = 8;
  localparam int NREG  = 2 * CH + 2;
  localparam int NEVER = 32'h3fff_ffff;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] period_tick;

  bpio_pwm_bank_if #(.MC_ADD_WIDTH(6), .MC_DATA_WIDTH(16)) bus ();

  bpio_pwm_bank #(
    .CHANNELS(CH), .CNT_WIDTH(16), .MC_ADD_WIDTH(6), .MC_DATA_WIDTH(16), .BASE_ADD(6'h08)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int mreg[NREG];

  // Expected-waveform state for the channel under test
  bit            m_active = 1'b0;
  int            m_ch, m_p, m_dold, m_dnew;
  logic [CH-1:0] m_pol;
  int            m_en = NEVER, m_dchg = NEVER, m_dis = NEVER;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance to the next falling edge and compare outputs against the model.
  task automatic step();
    int c, k, len, pos, j, s, d;
    logic ob, tk;
    logic [CH-1:0] eo, et;
    @(negedge clock);
    if (m_active) begin
      c   = cyc;
      len = m_p + 1;
      ob  = m_pol[m_ch];
      tk  = 1'b0;
      if (c >= m_en && c <= m_dis) begin
        k = c - m_en;
        if (k > 0) begin
          pos = (k - 1) % len;
          j   = (k - 1) / len;
          s   = m_en + j * len;
          d   = (m_dchg < s) ? m_dnew : m_dold;
          ob  = (pos < d) ^ m_pol[m_ch];
        end
        tk = (c < m_dis) && ((k % len) == m_p);
      end
      eo = m_pol;
      eo[m_ch] = ob;
      et = '0;
      et[m_ch] = tk;
      chk($sformatf("pwm_out ch%0d", m_ch), 32'(pwm_out), 32'(eo));
      chk($sformatf("period_tick ch%0d", m_ch), 32'(period_tick), 32'(et));
    end
  endtask

  // code: 1 marks enable commit, 2 duty change commit, 3 disable commit.
  task automatic bus_write(input int a, input int d, input int code);
    int idx;
    step();
    bus.mc_add     = 6'(a);
    bus.mc_data_in = 16'(d);
    bus.mc_ce      = 1'b0;
    bus.mc_we      = 1'b0;
    case (code)
      1: m_en   = cyc + 3;
      2: m_dchg = cyc + 3;
      3: m_dis  = cyc + 3;
      default: ;
    endcase
    idx = a - BASE;
    if (idx >= 0 && idx < NREG) mreg[idx] = (idx >= 2 * CH) ? (d & 31) : (d & 16'hffff);
    repeat (4) step();
    bus.mc_we = 1'b1;
    bus.mc_ce = 1'b1;
    repeat (4) step();
  endtask

  task automatic bus_read(input int a, input logic exp_oe, input int exp_d, input string tag);
    step();
    bus.mc_add = 6'(a);
    bus.mc_ce  = 1'b0;
    bus.mc_oe  = 1'b0;
    #1;
    chk({tag, " data_oe"}, 32'(bus.mc_data_oe), 32'(exp_oe));
    chk({tag, " data_out"}, 32'(bus.mc_data_out), 32'(exp_d));
    bus.mc_ce = 1'b1;
    bus.mc_oe = 1'b1;
  endtask

  task automatic trial(input int ch, input int p, input int dold, input int dnew, input int pol);
    bus_write(BASE + 2 * ch, p, 0);
    bus_write(BASE + 2 * ch + 1, dold, 0);
    bus_write(BASE + 2 * CH + 1, pol, 0);
    m_ch = ch; m_p = p; m_dold = dold; m_dnew = dnew; m_pol = CH'(pol);
    m_en = NEVER; m_dchg = NEVER; m_dis = NEVER;
    m_active = 1'b1;
    bus_write(BASE + 2 * CH, 1 << ch, 1);
    repeat ($urandom_range(0, 2 * (p + 1))) step();
    bus_write(BASE + 2 * ch + 1, dnew, 2);
    repeat (2 * (p + 1) + $urandom_range(0, p)) step();
    bus_write(BASE + 2 * CH, 0, 3);
    step();
    m_active = 1'b0;
  endtask

  initial begin
    int p;
    bus.mc_ce = 1'b1; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    bus.mc_add = '0;  bus.mc_data_in = '0;
    foreach (mreg[i]) mreg[i] = 0;

    // Strobes while in reset must leave everything cleared
    repeat (3) begin
      @(negedge clock);
      bus.mc_ce = 1'b0; bus.mc_we = 1'b0; bus.mc_add = 6'h08; bus.mc_data_in = 16'hffff;
      @(negedge clock);
      bus.mc_we = 1'b1;
    end
    repeat (4) @(negedge clock);
    chk("reset pwm_out", 32'(pwm_out), 32'h0);
    chk("reset period_tick", 32'(period_tick), 32'h0);
    bus.mc_oe = 1'b0;
    #1;
    chk("reset data_oe", 32'(bus.mc_data_oe), 32'h0);
    bus.mc_oe = 1'b1; bus.mc_ce = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (5) step();
    for (int i = 0; i < NREG; i++) bus_read(BASE + i, 1'b1, 0, $sformatf("post-reset reg%0d", i));

    bus_write(BASE + 1, 16'habcd, 0);
    bus_read(BASE + 1, 1'b1, 16'habcd, "readback duty0");
    bus_read(6'h20, 1'b0, 0, "unmapped 0x20");
    bus_read(6'h07, 1'b0, 0, "unmapped 0x07");
    bus_read(6'h14, 1'b0, 0, "unmapped 0x14");
    bus_read(6'h13, 1'b1, 0, "pol reg");
    bus_write(6'h30, 16'h1111, 0);

    // Reset lands in the middle of a strobe that stays low past release
    bus_write(BASE + 2, 16'h1234, 0);
    bus_read(BASE + 2, 1'b1, 16'h1234, "period1 before reset");
    step();
    bus.mc_add = 6'(BASE + 2); bus.mc_data_in = 16'h5555; bus.mc_ce = 1'b0; bus.mc_we = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("mid-write reset pwm_out", 32'(pwm_out), 32'h0);
    step();
    reset = 1'b1;
    repeat (4) step();
    bus.mc_we = 1'b1; bus.mc_ce = 1'b1;
    repeat (4) step();
    foreach (mreg[i]) mreg[i] = 0;
    bus_read(BASE + 2, 1'b1, 0, "dropped strobe period1");
    bus_read(BASE + 1, 1'b1, 0, "reset cleared duty0");

    trial(0, 9, 3, 7, 0);
    trial(1, 0, 1, 1, 0);
    trial(1, 9, 20, 0, 0);
    trial(1, 9, 0, 5, 0);
    trial(2, 3, 1, 1, 5'h04);
    for (int t = 0; t < 16; t++) begin
      p = $urandom_range(0, 12);
      trial($urandom_range(0, CH - 1), p, $urandom_range(0, p + 3), $urandom_range(0, p + 3),
            $urandom_range(0, 31));
    end

    for (int i = 0; i < NREG; i++) bus_read(BASE + i, 1'b1, mreg[i], $sformatf("final reg%0d", i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
